// File: rtl/bp_pkg.sv
// Shared definitions for the BTB branch predictor: prediction-mode encodings
// and direction-counter constant helpers.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_STATIC  = 2'd0,
        BP_BTB     = 2'd1,
        BP_BTB_CNT = 2'd2
    } bp_mode_e;

    // Weakly not-taken: 01..1, i.e. one below the taken threshold.
    function automatic logic [31:0] cnt_weak_nt(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] cnt_weak_t(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Predictor <-> pipeline signal bundle; the core drives through master, the
// predictor receives through slave.
interface branch_predictor_btb_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc_if;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  bubbleD;
    logic                  flushD;
    logic                  bubbleE;
    logic                  flushE;
    logic                  ex_valid;
    logic                  ex_is_branch;
    logic [ADDR_WIDTH-1:0] ex_pc;
    logic                  ex_taken;
    logic [ADDR_WIDTH-1:0] ex_target;
    logic                  mispredict;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [31:0]           br_count;
    logic [31:0]           mispred_count;

    modport master (
        output pc_if, bubbleD, flushD, bubbleE, flushE,
               ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               br_count, mispred_count
    );

    modport slave (
        input  pc_if, bubbleD, flushD, bubbleE, flushE,
               ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               br_count, mispred_count
    );
endinterface

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter with a parallel load; load has priority over
// inc, inc over dec.
module bp_sat_counter #(
    parameter int               WIDTH = 2,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_next_s;

    // Next value, clamped at both ends.
    always_comb begin
        count_next_s = count;
        if (load) begin
            count_next_s = load_value;
        end else if (inc && (count != MAX_VAL)) begin
            count_next_s = count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (dec && (count != {WIDTH{1'b0}})) begin
            count_next_s = count - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = count;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= INIT;
        end else begin
            count <= count_next_s;
        end
    end
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry direction counters: predicts in IF, carries
// the prediction through ID/EX, resolves and trains from EX.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int ENTRY_BITS   = 6,
    parameter int COUNTER_BITS = 2,
    parameter int PREDICT_MODE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predictor_btb_if.slave bus
);
    localparam int ENTRIES = 1 << ENTRY_BITS;
    localparam int TAG_W   = ADDR_WIDTH - ENTRY_BITS - 2;
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'(cnt_weak_nt(COUNTER_BITS));
    localparam logic [COUNTER_BITS-1:0] CNT_WT   = COUNTER_BITS'(cnt_weak_t(COUNTER_BITS));

    logic                    valid_r  [ENTRIES];
    logic [TAG_W-1:0]        tag_r    [ENTRIES];
    logic [ADDR_WIDTH-1:0]   target_r [ENTRIES];
    logic [COUNTER_BITS-1:0] cnt_s    [ENTRIES];

    logic [ENTRY_BITS-1:0] idx_if_s, idx_ex_s;
    logic [TAG_W-1:0]      tag_if_s, tag_ex_s;
    logic                  hit_if_s, hit_ex_s;
    logic                  pred_taken_s;
    logic                  br_ev_s, upd_s, mispredict_s;
    logic [ADDR_WIDTH-1:0] seq_pc_s, redirect_s;
    logic                  pred_d_taken_r, pred_e_taken_r;
    logic [ADDR_WIDTH-1:0] pred_d_target_r, pred_e_target_r;
    logic [31:0]           br_count_r, mispred_count_r;
    logic                  unused_pc_bits_s;

    assign idx_if_s = bus.pc_if[ENTRY_BITS+1:2];
    assign tag_if_s = bus.pc_if[ADDR_WIDTH-1:ENTRY_BITS+2];
    assign idx_ex_s = bus.ex_pc[ENTRY_BITS+1:2];
    assign tag_ex_s = bus.ex_pc[ADDR_WIDTH-1:ENTRY_BITS+2];
    assign unused_pc_bits_s = ^bus.pc_if[1:0];

    // IF lookup; sees table state from before any same-cycle training.
    always_comb begin
        hit_if_s     = valid_r[idx_if_s] && (tag_r[idx_if_s] == tag_if_s);
        pred_taken_s = 1'b0;
        case (PREDICT_MODE)
            int'(BP_STATIC):  pred_taken_s = 1'b0;
            int'(BP_BTB):     pred_taken_s = hit_if_s;
            int'(BP_BTB_CNT): pred_taken_s = hit_if_s && (cnt_s[idx_if_s] >= CNT_WT);
            default:          pred_taken_s = 1'b0;
        endcase
    end

    // EX resolution against the prediction that travelled with the instruction.
    always_comb begin
        br_ev_s      = bus.ex_valid && bus.ex_is_branch;
        upd_s        = br_ev_s && !bus.bubbleE;
        hit_ex_s     = valid_r[idx_ex_s] && (tag_r[idx_ex_s] == tag_ex_s);
        seq_pc_s     = bus.ex_pc + ADDR_WIDTH'(4);
        mispredict_s = 1'b0;
        redirect_s   = seq_pc_s;
        if (br_ev_s) begin
            mispredict_s = (bus.ex_taken != pred_e_taken_r) ||
                           (bus.ex_taken && (bus.ex_target != pred_e_target_r));
            redirect_s   = bus.ex_taken ? bus.ex_target : seq_pc_s;
        end else begin
            mispredict_s = 1'b0;
            redirect_s   = seq_pc_s;
        end
    end

    // Prediction pipe ID/EX; flush has priority over bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_d_taken_r  <= 1'b0;
            pred_d_target_r <= {ADDR_WIDTH{1'b0}};
            pred_e_taken_r  <= 1'b0;
            pred_e_target_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            if (bus.flushD) begin
                pred_d_taken_r  <= 1'b0;
                pred_d_target_r <= {ADDR_WIDTH{1'b0}};
            end else if (!bus.bubbleD) begin
                pred_d_taken_r  <= pred_taken_s;
                pred_d_target_r <= target_r[idx_if_s];
            end
            if (bus.flushE) begin
                pred_e_taken_r  <= 1'b0;
                pred_e_target_r <= {ADDR_WIDTH{1'b0}};
            end else if (!bus.bubbleE) begin
                pred_e_taken_r  <= pred_d_taken_r;
                pred_e_target_r <= pred_d_target_r;
            end
        end
    end

    // Tag/target table: a taken branch either refreshes its hit entry or
    // claims the slot outright; not-taken misses leave the table alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else if (upd_s && bus.ex_taken) begin
            valid_r[idx_ex_s]  <= 1'b1;
            tag_r[idx_ex_s]    <= tag_ex_s;
            target_r[idx_ex_s] <= bus.ex_target;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        logic sel_s;
        assign sel_s = upd_s && (idx_ex_s == ENTRY_BITS'(g));
        bp_sat_counter #(
            .WIDTH (COUNTER_BITS),
            .INIT  (CNT_INIT)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc        (sel_s && hit_ex_s && bus.ex_taken),
            .dec        (sel_s && hit_ex_s && !bus.ex_taken),
            .load       (sel_s && !hit_ex_s && bus.ex_taken),
            .load_value (CNT_WT),
            .count      (cnt_s[g])
        );
    end

    // Branch / mispredict statistics, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_r      <= 32'd0;
            mispred_count_r <= 32'd0;
        end else if (upd_s) begin
            br_count_r      <= br_count_r + 32'd1;
            mispred_count_r <= mispred_count_r + {31'd0, mispredict_s};
        end
    end

    assign bus.pred_taken    = pred_taken_s;
    assign bus.pred_target   = target_r[idx_if_s];
    assign bus.mispredict    = mispredict_s;
    assign bus.redirect_pc   = redirect_s;
    assign bus.br_count      = br_count_r;
    assign bus.mispred_count = mispred_count_r;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: a mode-2 and a mode-0 instance share one
// stimulus stream and are checked each cycle against a table-level model.
module tb_branch_predictor_btb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] pc, ex_pc_v, ex_tg;
    logic        b_d, f_d, b_e, f_e, exv, exb, ext;

    branch_predictor_btb_if #(.ADDR_WIDTH(32)) bus0 ();
    branch_predictor_btb_if #(.ADDR_WIDTH(32)) bus1 ();

    assign bus0.pc_if = pc;        assign bus1.pc_if = pc;
    assign bus0.bubbleD = b_d;     assign bus1.bubbleD = b_d;
    assign bus0.flushD = f_d;      assign bus1.flushD = f_d;
    assign bus0.bubbleE = b_e;     assign bus1.bubbleE = b_e;
    assign bus0.flushE = f_e;      assign bus1.flushE = f_e;
    assign bus0.ex_valid = exv;    assign bus1.ex_valid = exv;
    assign bus0.ex_is_branch = exb; assign bus1.ex_is_branch = exb;
    assign bus0.ex_pc = ex_pc_v;   assign bus1.ex_pc = ex_pc_v;
    assign bus0.ex_taken = ext;    assign bus1.ex_taken = ext;
    assign bus0.ex_target = ex_tg; assign bus1.ex_target = ex_tg;

    branch_predictor_btb #(.ADDR_WIDTH(32), .ENTRY_BITS(6), .COUNTER_BITS(2), .PREDICT_MODE(2))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    branch_predictor_btb #(.ADDR_WIDTH(32), .ENTRY_BITS(6), .COUNTER_BITS(2), .PREDICT_MODE(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;

    // Model: lane 0 = counter mode, lane 1 = static not-taken.
    logic        mv   [64];
    logic [31:0] mtag [64];
    logic [31:0] mtgt [64];
    int          mcnt [64];
    logic        pdt [2], pet [2];
    logic [31:0] pdg [2], peg [2];
    logic [31:0] mbc;
    logic [31:0] mmc [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int ix(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    function automatic logic lhit(input logic [31:0] a);
        return mv[ix(a)] && (mtag[ix(a)] == (a >> 8));
    endfunction

    function automatic logic mpred(input int lane, input logic [31:0] a);
        if (lane == 1) return 1'b0;
        return lhit(a) && (mcnt[ix(a)] >= 2);
    endfunction

    function automatic logic mmis(input int lane);
        if (!(exv && exb)) return 1'b0;
        return (ext != pet[lane]) || (ext && (ex_tg != peg[lane]));
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0; mtag[i] = 32'd0; mtgt[i] = 32'd0; mcnt[i] = 1;
        end
        for (int l = 0; l < 2; l++) begin
            pdt[l] = 1'b0; pet[l] = 1'b0; pdg[l] = 32'd0; peg[l] = 32'd0; mmc[l] = 32'd0;
        end
        mbc = 32'd0;
    endtask

    task automatic chk_lane(input int l, input logic pt, input logic [31:0] tg, input logic mp,
                            input logic [31:0] rd, input logic [31:0] bc, input logic [31:0] mc);
        logic [31:0] exp_rd;
        exp_rd = (exv && exb && ext) ? ex_tg : ex_pc_v + 32'd4;
        chk($sformatf("pred_taken[%0d]", l), {31'd0, pt}, {31'd0, mpred(l, pc)});
        if (mpred(l, pc)) chk($sformatf("pred_target[%0d]", l), tg, mtgt[ix(pc)]);
        chk($sformatf("mispredict[%0d]", l), {31'd0, mp}, {31'd0, mmis(l)});
        chk($sformatf("redirect_pc[%0d]", l), rd, exp_rd);
        chk($sformatf("br_count[%0d]", l), bc, mbc);
        chk($sformatf("mispred_count[%0d]", l), mc, mmc[l]);
    endtask

    task automatic model_next();
        logic        pr  [2];
        logic        mis [2];
        logic [31:0] ptg;
        int          i;
        ptg = mtgt[ix(pc)];
        for (int l = 0; l < 2; l++) begin
            pr[l]  = mpred(l, pc);
            mis[l] = mmis(l);
        end
        if (exv && exb && !b_e) begin
            mbc++;
            for (int l = 0; l < 2; l++) if (mis[l]) mmc[l]++;
            i = ix(ex_pc_v);
            if (lhit(ex_pc_v)) begin
                if (ext) begin
                    if (mcnt[i] < 3) mcnt[i]++;
                    mtgt[i] = ex_tg;
                end else if (mcnt[i] > 0) begin
                    mcnt[i]--;
                end
            end else if (ext) begin
                mv[i] = 1'b1; mtag[i] = ex_pc_v >> 8; mtgt[i] = ex_tg; mcnt[i] = 2;
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (f_e) begin
                pet[l] = 1'b0; peg[l] = 32'd0;
            end else if (!b_e) begin
                pet[l] = pdt[l]; peg[l] = pdg[l];
            end
            if (f_d) begin
                pdt[l] = 1'b0; pdg[l] = 32'd0;
            end else if (!b_d) begin
                pdt[l] = pr[l]; pdg[l] = ptg;
            end
        end
    endtask

    task automatic cycle_body();
        chk_lane(0, bus0.pred_taken, bus0.pred_target, bus0.mispredict, bus0.redirect_pc,
                 bus0.br_count, bus0.mispred_count);
        chk_lane(1, bus1.pred_taken, bus1.pred_target, bus1.mispredict, bus1.redirect_pc,
                 bus1.br_count, bus1.mispred_count);
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        cycle_body();
    endtask

    task automatic idle();
        exv = 1'b0; exb = 1'b0; ext = 1'b0; ex_pc_v = 32'd0; ex_tg = 32'd0;
        b_d = 1'b0; f_d = 1'b0; b_e = 1'b0; f_e = 1'b0;
    endtask

    // Branch at a: looked up in IF (optionally flushed out of ID), resolved two cycles later.
    task automatic run_branch(input logic [31:0] a, input logic tk, input logic [31:0] tg,
                              input logic fl, input int lm0, input int lm1, input logic [31:0] rd);
        idle(); pc = a; f_d = fl; step();
        f_d = 1'b0; pc = 32'h404; step();
        exv = 1'b1; exb = 1'b1; ext = tk; ex_pc_v = a; ex_tg = tg; #1;
        if (lm0 >= 0) begin
            chk("lit_mispredict0", {31'd0, bus0.mispredict}, lm0);
            chk("lit_redirect", bus0.redirect_pc, rd);
        end
        if (lm1 >= 0) chk("lit_mispredict1", {31'd0, bus1.mispredict}, lm1);
        step();
        idle();
    endtask

    task automatic lookup(input logic [31:0] a, input int lp0, input logic [31:0] ltg);
        idle(); pc = a; #1;
        chk("lit_pred_taken0", {31'd0, bus0.pred_taken}, lp0);
        if (lp0 == 1) chk("lit_pred_target0", bus0.pred_target, ltg);
        chk("lit_pred_taken1", {31'd0, bus1.pred_taken}, 32'd0);
        step();
    endtask

    initial begin
        idle(); pc = 32'h100; rst = 1'b1; reset_model();
        #2;
        chk("rst_pred_taken", {31'd0, bus0.pred_taken}, 32'd0);
        chk("rst_br_count", bus0.br_count, 32'd0);
        chk("rst_mispred_count", bus0.mispred_count, 32'd0);
        @(negedge clk); rst = 1'b0; #1; cycle_body();

        // cold taken branch, then trained lookup
        run_branch(32'h100, 1'b1, 32'h80, 1'b0, 1, 1, 32'h80);
        lookup(32'h100, 1, 32'h80);
        chk("pin_cnt_alloc", mcnt[0], 32'd2);

        // train down to 00, then saturate at 11
        run_branch(32'h100, 1'b0, 32'h80, 1'b0, 1, 0, 32'h104);
        run_branch(32'h100, 1'b0, 32'h80, 1'b0, 0, 0, 32'h104);
        lookup(32'h100, 0, 32'h0);
        chk("pin_cnt_floor", mcnt[0], 32'd0);
        for (int k = 0; k < 4; k++) run_branch(32'h100, 1'b1, 32'h80, 1'b0, -1, 1, 32'h80);
        chk("pin_cnt_ceiling", mcnt[0], 32'd3);
        run_branch(32'h100, 1'b0, 32'h80, 1'b0, 1, 0, 32'h104);
        lookup(32'h100, 1, 32'h80);

        // aliasing: same index, different tags
        run_branch(32'h200, 1'b1, 32'h300, 1'b0, 1, 1, 32'h300);
        run_branch(32'h100, 1'b1, 32'h80,  1'b0, 1, 1, 32'h80);
        run_branch(32'h200, 1'b1, 32'h300, 1'b0, 1, 1, 32'h300);
        lookup(32'h200, 1, 32'h300);
        lookup(32'h100, 0, 32'h0);

        // flushed prediction in ID
        run_branch(32'h200, 1'b1, 32'h300, 1'b1, 1, 1, 32'h300);
        run_branch(32'h200, 1'b0, 32'h300, 1'b1, 0, 0, 32'h204);

        // EX stalled three cycles trains once
        idle(); pc = 32'h404;
        exv = 1'b1; exb = 1'b1; ext = 1'b1; ex_pc_v = 32'h200; ex_tg = 32'h300; b_e = 1'b1;
        step(); step(); step();
        b_e = 1'b0; step();
        idle(); #1;
        chk("lit_br_count_stall", bus0.br_count, 32'd14);
        chk("lit_br_count_stall1", bus1.br_count, 32'd14);
        step();

        // static mode ignores the trained entry
        lookup(32'h200, 1, 32'h300);
        run_branch(32'h200, 1'b1, 32'h300, 1'b0, 0, 1, 32'h300);

        // asynchronous reset between edges
        idle(); pc = 32'h200; #2;
        rst = 1'b1; #1;
        chk("arst_pred_taken", {31'd0, bus0.pred_taken}, 32'd0);
        chk("arst_br_count", bus0.br_count, 32'd0);
        chk("arst_mispred_count0", bus0.mispred_count, 32'd0);
        chk("arst_mispred_count1", bus1.mispred_count, 32'd0);
        reset_model();
        @(negedge clk); rst = 1'b0; #1; cycle_body();
        run_branch(32'h200, 1'b1, 32'h300, 1'b0, 1, 1, 32'h300);
        lookup(32'h200, 1, 32'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
